mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter op_w, 6, opcode field width; SHALL be the width of opcode and funct.
REQ-002 Parameter wait_max, 15, memory wait-state limit; SHALL be the number of cycles without mem_ready after which a memory state aborts to TRAP.
REQ-003 Port list SHALL be as follows; clock is clk, and reset is Rnot, asynchronous active-low.
- clk  in  1  rising-edge clock
- Rnot  in  1  asynchronous active-low reset
- opcode  in  op_w  IR[31:26]
- funct  in  op_w  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables
- i_or_d, alu_src_a, reg_dst, mem_to_reg  out  1 each  mux selects
- alu_src_b, alu_op, pc_source  out  2 each  mux selects / ALU class (00 add, 01 sub, 10 funct)
- state  out  4  current state code
- illegal  out  1  sticky trap flag

Function
REQ-004 SHALL be a multi-cycle FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB, TRAP.
REQ-005 FETCH SHALL hold mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL equal mem_ready; SHALL advance to DECODE only when mem_ready=1.
REQ-006 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 and branch on opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->TRAP.
REQ-007 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; SHALL go to MEMRD for lw and MEMWR for sw.
REQ-008 MEMRD SHALL drive mem_read=1, i_or_d=1; SHALL go to MEMWB on mem_ready, else stay.
REQ-009 MEMWR SHALL drive mem_write=1, i_or_d=1; SHALL go to FETCH on mem_ready, else stay.
REQ-010 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-011 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALUWB; ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-012 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; the PC SHALL load only when zero=1; then go to FETCH.
REQ-013 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-014 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDIWB; ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-015 Unlisted outputs in every state SHALL be 0.
REQ-016 A wait counter SHALL count consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready=0; on reaching wait_max it SHALL force TRAP; it SHALL clear on mem_ready=1 or on a state change.
REQ-017 TRAP SHALL set illegal=1, deassert all enables, and hold until reset.
REQ-018 Zero-wait latency SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
REQ-019 Outputs other than ir_write, pc_write (FETCH) and pc_write_cond SHALL be Moore-decoded from state only.

Reset
REQ-020 Rnot=0 SHALL immediately force state=FETCH (code 0), clear the wait counter and illegal, and drive the FETCH output set of REQ-005.
REQ-021 Reset asserted mid-instruction SHALL abandon that instruction with no further reg_write or mem_write.

Configuration
REQ-022 With MC_CTRL_ADDI_EN defined, opcode 001000 SHALL execute through ADDIEX/ADDIWB; without it, 001000 SHALL go to TRAP and ADDIEX/ADDIWB SHALL not be synthesised.

Structure
REQ-023 Package mc_pkg SHALL hold the state enum, opcode constants, alu_op encodings and pc_source encodings.
REQ-024 Combinational output decoding SHALL live in sub-module mc_out_decode; the state register and wait counter SHALL stay in mc_controller.

Verification
REQ-025 Reset, then opcode=000000 with mem_ready=1 held -> states FETCH,DECODE,EXEC,ALUWB,FETCH; reg_write=1 and reg_dst=1 in cycle 4 only.
REQ-026 lw (100011) with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1, reg_write=1.
REQ-027 beq with zero=0, then with zero=1 -> pc_write_cond=1, pc_source=01 in BRANCH both times; pc_write stays 0.
REQ-028 opcode=111111 -> TRAP after DECODE; illegal=1 sticky; Rnot pulse low -> state=0, illegal=0.
REQ-029 mem_ready held 0 in FETCH for wait_max=15 cycles -> TRAP, no ir_write ever asserted.
REQ-030 addi (001000) built with and without MC_CTRL_ADDI_EN -> ADDIEX,ADDIWB with reg_write in ADDIWB versus TRAP with illegal=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding, opcode
// values, ALU class, PC source and ALU B-operand select encodings.
// Optional feature macro: MC_CTRL_ADDI_EN (adds the ADDIEX/ADDIWB path).
package mc_pkg;

  // FETCH must stay at code 0; it is the reset state seen on the state port.
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
`ifdef MC_CTRL_ADDI_EN
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
`endif
    StTrap   = 4'd12
  } mc_state_e;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [5:0] OpAddi  = 6'b001000;
`endif

  // ALU operation class
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // States that wait on the memory handshake and are guarded by the wait counter
  function automatic logic is_wait_state(mc_state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Output decoder for the multi-cycle controller. Every output is a pure
// function of the current state, except ir_write/pc_write in FETCH which
// follow mem_ready so the IR and PC load on the cycle the fetch completes.
// Optional feature macro: MC_CTRL_ADDI_EN (decodes ADDIEX/ADDIWB).
// Ports:
//   state_i        current state code
//   mem_ready_i    memory handshake
//   *_o            datapath enables, mux selects and ALU class
import mc_pkg::*;

module mc_out_decode (
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       alu_src_a_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    i_or_d_o        = 1'b0;
    alu_src_a_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_b_o     = SrcBReg;
    alu_op_o        = AluAdd;
    pc_source_o     = PcSrcAlu;

    unique case (mc_state_e'(state_i))
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SrcBFour;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: begin
        alu_src_b_o = SrcBImmSh;
      end
      StMemAdr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
      end
      StMemRd: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      StMemWr: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StExec: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = AluFunct;
      end
      StAluWb: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      StBranch: begin
        // The datapath gates the PC load with the ALU zero flag.
        alu_src_a_o     = 1'b1;
        alu_op_o        = AluSub;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PcSrcBranch;
      end
      StJump: begin
        pc_write_o  = 1'b1;
        pc_source_o = PcSrcJump;
      end
`ifdef MC_CTRL_ADDI_EN
      StAddiEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
      end
      StAddiWb: begin
        reg_write_o = 1'b1;
      end
`endif
      default: ; // TRAP and unused codes: everything deasserted
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle processor control FSM. Holds the state register, the memory
// wait-state counter and the sticky illegal flag; output decoding is done in
// mc_out_decode.
// Optional feature macro: MC_CTRL_ADDI_EN (opcode 001000 runs ADDIEX/ADDIWB,
// otherwise it traps).
// Ports:
//   clk, Rnot             clock, asynchronous active-low reset
//   opcode, funct         instruction fields IR[31:26], IR[5:0]
//   zero, mem_ready       ALU zero flag, memory access complete
//   pc_write .. mem_write datapath enables
//   i_or_d .. pc_source   mux selects and ALU class
//   state                 current state code
//   illegal               sticky trap flag
import mc_pkg::*;

module mc_controller #(
  parameter int unsigned op_w     = 6,
  parameter int unsigned wait_max = 15
) (
  input  logic            clk,
  input  logic            Rnot,
  input  logic [op_w-1:0] opcode,
  input  logic [op_w-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            ir_write,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            i_or_d,
  output logic            alu_src_a,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic [3:0]      state,
  output logic            illegal
);

  localparam int unsigned WaitW = $clog2(wait_max + 1);

  mc_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             stalled;

  // funct goes to the ALU control and zero gates the PC in the datapath;
  // the controller itself does not decode them.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  assign stalled = is_wait_state(state_q) && !mem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (opcode == op_w'(OpRType)) begin
          state_d = StExec;
        end else if ((opcode == op_w'(OpLw)) || (opcode == op_w'(OpSw))) begin
          state_d = StMemAdr;
        end else if (opcode == op_w'(OpBeq)) begin
          state_d = StBranch;
        end else if (opcode == op_w'(OpJ)) begin
          state_d = StJump;
`ifdef MC_CTRL_ADDI_EN
        end else if (opcode == op_w'(OpAddi)) begin
          state_d = StAddiEx;
`endif
        end else begin
          state_d = StTrap;
        end
      end
      StMemAdr: begin
        // The IR is stable, so opcode still identifies lw vs sw here.
        if (opcode == op_w'(OpLw)) begin
          state_d = StMemRd;
        end else if (opcode == op_w'(OpSw)) begin
          state_d = StMemWr;
        end else begin
          state_d = StTrap;
        end
      end
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StMemWb:  state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
`ifdef MC_CTRL_ADDI_EN
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
`endif
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase

    // wait_q counts stalled cycles already completed, so this is the
    // wait_max-th consecutive cycle without mem_ready.
    if (stalled && (wait_q == WaitW'(wait_max - 1))) begin
      state_d = StTrap;
    end
  end

  always_comb begin
    wait_d = '0;
    if (stalled && (state_d == state_q)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  assign illegal_d = illegal_q || (state_d == StTrap);

  always_ff @(posedge clk or negedge Rnot) begin
    if (!Rnot) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

  mc_out_decode u_out_decode (
    .state_i         (state_q),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .ir_write_o      (ir_write),
    .reg_write_o     (reg_write),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .i_or_d_o        (i_or_d),
    .alu_src_a_o     (alu_src_a),
    .reg_dst_o       (reg_dst),
    .mem_to_reg_o    (mem_to_reg),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .pc_source_o     (pc_source)
  );

endmodule
